// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the alu_seq_ctrl program sequencer.
package alu_seq_pkg;

  localparam int ALU_DW = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  typedef struct packed {
    logic [1:0]        op;
    logic [ALU_DW-1:0] data;
  } instr_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/alu_seq_progmem.sv
// Program store: DEPTH x W register file, one synchronous write port and
// one asynchronous read port, cleared to zero by reset.
module alu_seq_progmem #(
  parameter int DEPTH = 8,
  parameter int W     = 6,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];

  always_comb begin
    // NOTE: the whole array gets a default copy first so no slot can infer a latch.
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // NOTE: the slots carry an async reset so an unprogrammed run reads zeros;
  // state flops take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Program sequencer feeding op/operand/hold to the 4-bit ALU datapath.
// Optional carry-stop early termination: define ALU_SEQ_CARRY_STOP_EN.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [1:0]    cfg_op,
  input  logic [DW-1:0] cfg_data,
  input  logic          cfg_last,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          early,
  output logic [1:0]    alu_op,
  output logic [DW-1:0] alu_data,
  output logic          alu_hold,
  input  logic          alu_carry
);

  localparam int AW = ptr_w(DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = 2 + DW;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [LW-1:0] len_q, len_d;
  logic          full_q, full_d;
  logic          ran_q, ran_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          early_q, early_d;
  logic          hold_q, hold_d;
  logic [1:0]    op_q, op_d;
  logic [DW-1:0] data_q, data_d;

  logic          mem_we;
  logic [AW-1:0] mem_raddr;
  logic [AW-1:0] wr_addr;
  logic [IW-1:0] mem_rdata;
  logic [1:0]    rd_op;
  logic [DW-1:0] rd_data;
  logic          cfg_ok;
  logic          last_slot;
  logic          stop;

  alu_seq_progmem #(
    .DEPTH (DEPTH),
    .W     (IW),
    .AW    (AW)
  ) u_progmem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (wr_addr),
    .wdata ({cfg_op, cfg_data}),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  assign rd_op   = mem_rdata[IW-1 -: 2];
  assign rd_data = mem_rdata[DW-1:0];

  // After a completed run the next write starts a fresh program at slot 0.
  assign wr_addr   = ran_q ? '0 : wr_ptr_q;
  assign cfg_ok    = (state_q == ST_IDLE) && !full_q && !start;
  assign last_slot = (LW'(pc_q) == (len_q - LW'(1)));

`ifdef ALU_SEQ_CARRY_STOP_EN
  logic last_add_q, last_add_d;

  assign last_add_d = (state_q == ST_RUN) && (op_q == OP_ADD);
  // Carry seen right after an ADD squashes the slot on the bus this cycle.
  assign stop       = (state_q == ST_RUN) && last_add_q && alu_carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_add_q <= 1'b0;
    else     last_add_q <= last_add_d;
  end
`else
  logic unused_carry;

  assign unused_carry = alu_carry;
  assign stop         = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    len_d     = len_q;
    pc_d      = pc_q;
    full_d    = full_q;
    ran_d     = ran_q;
    early_d   = early_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    hold_d    = 1'b1;
    op_d      = '0;
    data_d    = '0;
    mem_we    = 1'b0;
    mem_raddr = '0;
    case (state_q)
      ST_IDLE: begin
        if (start && (len_q != '0)) begin
          state_d = ST_RUN;
          pc_d    = '0;
          early_d = 1'b0;
          busy_d  = 1'b1;
          hold_d  = 1'b0;
          op_d    = rd_op;
          data_d  = rd_data;
        end else if (cfg_valid && cfg_ok) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_addr + AW'(1);
          ran_d    = 1'b0;
          if (ran_q) len_d = '0;
          if (cfg_last || (wr_addr == AW'(DEPTH - 1))) begin
            full_d = 1'b1;
            len_d  = LW'(wr_addr) + LW'(1);
          end
        end
      end
      ST_RUN: begin
        mem_raddr = pc_q + AW'(1);
        if (stop || last_slot) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          full_d  = 1'b0;
          ran_d   = 1'b1;
          early_d = stop;
        end else begin
          pc_d   = pc_q + AW'(1);
          busy_d = 1'b1;
          hold_d = 1'b0;
          op_d   = rd_op;
          data_d = rd_data;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      len_q    <= '0;
      pc_q     <= '0;
      full_q   <= 1'b0;
      ran_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      early_q  <= 1'b0;
      hold_q   <= 1'b1;
      op_q     <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      len_q    <= len_d;
      pc_q     <= pc_d;
      full_q   <= full_d;
      ran_q    <= ran_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      early_q  <= early_d;
      hold_q   <= hold_d;
      op_q     <= op_d;
      data_q   <= data_d;
    end
  end

  assign cfg_ready = cfg_ok;
  assign busy      = busy_q;
  assign done      = done_q;
  assign early     = early_q;
  assign alu_op    = op_q;
  assign alu_data  = data_q;
  assign alu_hold  = hold_q | stop;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: accumulator model, trace-level reference model,
// per-cycle compare plus directed literal checks.
`timescale 1ns/1ps
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  localparam int DEPTH = 8;
  localparam int DW    = 4;
`ifdef ALU_SEQ_CARRY_STOP_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid, cfg_ready, cfg_last, start;
  logic [1:0]    cfg_op;
  logic [DW-1:0] cfg_data;
  logic          busy, done, early, alu_hold, alu_carry;
  logic [1:0]    alu_op;
  logic [DW-1:0] alu_data;

  alu_seq_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_op    (cfg_op),
    .cfg_data  (cfg_data),
    .cfg_last  (cfg_last),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .early     (early),
    .alu_op    (alu_op),
    .alu_data  (alu_data),
    .alu_hold  (alu_hold),
    .alu_carry (alu_carry)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Accumulator datapath driven by the sequencer; carry is its registered flag.
  logic [DW-1:0] acc_q;
  logic          carry_q;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else if (!alu_hold) begin
      case (alu_op)
        2'b00:   begin acc_q <= acc_q & alu_data; carry_q <= 1'b0; end
        2'b01:   begin acc_q <= acc_q | alu_data; carry_q <= 1'b0; end
        2'b10:   begin acc_q <= acc_q ^ alu_data; carry_q <= 1'b0; end
        default: {carry_q, acc_q} <= {1'b0, acc_q} + {1'b0, alu_data};
      endcase
    end
  end
  assign alu_carry = carry_q;

  // Reference model: on each accepted start the whole per-cycle output trace
  // of the run is planned from the program and the accumulator value.
  typedef struct packed {
    logic          busy;
    logic          hold;
    logic          done;
    logic          early;
    logic [1:0]    op;
    logic [DW-1:0] data;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   cur;
  instr_t prog [DEPTH];
  int     m_len, m_wr;
  bit     m_full, m_ran, m_early;

  function automatic exp_t mk(input logic b, input logic h, input logic d, input logic e,
                              input logic [1:0] op, input logic [DW-1:0] dat);
    exp_t r;
    r.busy = b; r.hold = h; r.done = d; r.early = e; r.op = op; r.data = dat;
    return r;
  endfunction

  function automatic void plan_run();
    logic [DW-1:0] a;
    logic [DW:0]   s;
    bit            c, e;
    a = acc_q; c = 1'b0; e = 1'b0;
    for (int k = 0; k < m_len; k++) begin
      if (STOP_EN && k > 0 && prog[k-1].op == OP_ADD && c) begin
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, prog[k].op, prog[k].data));
        e = 1'b1;
        break;
      end
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, prog[k].op, prog[k].data));
      case (prog[k].op)
        OP_AND:  begin a = a & prog[k].data; c = 1'b0; end
        OP_OR:   begin a = a | prog[k].data; c = 1'b0; end
        OP_XOR:  begin a = a ^ prog[k].data; c = 1'b0; end
        default: begin s = {1'b0, a} + {1'b0, prog[k].data}; a = s[DW-1:0]; c = s[DW]; end
      endcase
    end
    exp_q.push_back(mk(1'b0, 1'b1, 1'b1, e, 2'b00, '0));
  endfunction

  function automatic void model_write();
    int wa;
    wa = m_ran ? 0 : m_wr;
    if (m_ran) m_len = 0;
    m_ran = 1'b0;
    prog[wa].op   = cfg_op;
    prog[wa].data = cfg_data;
    m_wr = (wa + 1) % DEPTH;
    if (cfg_last || wa == DEPTH - 1) begin
      m_full = 1'b1;
      m_len  = wa + 1;
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_len = 0; m_wr = 0; m_full = 1'b0; m_ran = 1'b0; m_early = 1'b0;
      for (int i = 0; i < DEPTH; i++) prog[i] = '0;
      cur = mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, '0);
    end else begin
      if (!cur.busy) begin
        if (start && m_len > 0) plan_run();
        else if (cfg_valid && !m_full && !start) model_write();
      end
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        if (cur.done) begin
          m_full  = 1'b0;
          m_ran   = 1'b1;
          m_early = cur.early;
        end
      end else begin
        cur = mk(1'b0, 1'b1, 1'b0, m_early, 2'b00, '0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("busy", busy, cur.busy);
      check("done", done, cur.done);
      check("early", early, cur.early);
      check("alu_hold", alu_hold, cur.hold);
      check("alu_op", alu_op, cur.op);
      check("alu_data", alu_data, cur.data);
      check("cfg_ready", cfg_ready, !cur.busy && !m_full && !start);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] op, input logic [DW-1:0] d, input logic last);
    cfg_valid = 1'b1; cfg_op = op; cfg_data = d; cfg_last = last;
    tick();
    cfg_valid = 1'b0; cfg_last = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Returns at the falling edge inside the done cycle, or flags a timeout.
  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check("done_within_budget", seen, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_last = 1'b0;
    cfg_op = 2'b00; cfg_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_early", early, 0);
    check("rst_hold", alu_hold, 1);
    check("rst_op", alu_op, 0);
    check("rst_data", alu_data, 0);
    check("rst_cfg_ready", cfg_ready, 1);

    // start with an empty program is ignored
    #1 pulse_start();
    @(negedge clk);
    check("empty_start_busy", busy, 0);
    check("empty_start_hold", alu_hold, 1);

    // ADD 3, XOR 5, AND F
    #1;
    wr(OP_ADD, 4'h3, 1'b0);
    wr(OP_XOR, 4'h5, 1'b0);
    wr(OP_AND, 4'hF, 1'b1);
    @(negedge clk);
    check("full_cfg_ready", cfg_ready, 0);
    #1 pulse_start();
    @(negedge clk);
    check("run1_s0_op", alu_op, 3);  check("run1_s0_data", alu_data, 3);
    check("run1_s0_busy", busy, 1);  check("run1_s0_hold", alu_hold, 0);
    @(negedge clk);
    check("run1_s1_op", alu_op, 2);  check("run1_s1_data", alu_data, 5);
    check("run1_acc_after_s0", acc_q, 3);
    @(negedge clk);
    check("run1_s2_op", alu_op, 0);  check("run1_s2_data", alu_data, 15);
    check("run1_acc_after_s1", acc_q, 6);
    @(negedge clk);
    check("run1_done", done, 1);     check("run1_done_busy", busy, 0);
    check("run1_acc_final", acc_q, 6);

    // back-to-back: start raised in the done cycle
    #1 pulse_start();
    @(negedge clk);
    check("b2b_busy", busy, 1);
    check("b2b_s0_op", alu_op, 3);   check("b2b_s0_data", alu_data, 3);
    wait_done(8);
    check("b2b_acc_final", acc_q, 12);

    // eight slots with no last flag fill the store
    #1;
    for (int k = 0; k < DEPTH; k++) wr(2'(k % 4), 4'(k + 1), 1'b0);
    @(negedge clk);
    check("fill8_cfg_ready", cfg_ready, 0);
    #1 pulse_start();
    wait_done(DEPTH + 4);
    check("fill8_ready_after_done", cfg_ready, 1);
    check("fill8_acc_final", acc_q, 8);

    // start and cfg_valid together: start wins, no write
    #1;
    start = 1'b1; cfg_valid = 1'b1; cfg_op = OP_ADD; cfg_data = 4'hF;
    tick();
    start = 1'b0; cfg_valid = 1'b0;
    @(negedge clk);
    check("collide_busy", busy, 1);
    check("collide_s0_op", alu_op, 0); check("collide_s0_data", alu_data, 1);
    wait_done(DEPTH + 4);

    // reset in the middle of a run
    #1 pulse_start();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_hold", alu_hold, 1);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("midrst_no_done", done, 0);
    end
    #1 pulse_start();
    @(negedge clk);
    check("midrst_len0_busy", busy, 0);

    // carry-stop scenario from accumulator 1: ADD F, ADD 1, OR 0
    #1;
    wr(OP_OR, 4'h1, 1'b1);
    pulse_start();
    wait_done(6);
    check("cs_acc_init", acc_q, 1);
    #1;
    wr(OP_ADD, 4'hF, 1'b0);
    wr(OP_ADD, 4'h1, 1'b0);
    wr(OP_OR,  4'h0, 1'b1);
    pulse_start();
    @(negedge clk);
    check("cs_s0_op", alu_op, 3);  check("cs_s0_data", alu_data, 15);
    check("cs_s0_hold", alu_hold, 0);
    @(negedge clk);
`ifdef ALU_SEQ_CARRY_STOP_EN
    check("cs_squash_hold", alu_hold, 1);
    check("cs_squash_busy", busy, 1);
    @(negedge clk);
    check("cs_done", done, 1);
    check("cs_early", early, 1);
    check("cs_acc_final", acc_q, 0);
`else
    check("cs_s1_hold", alu_hold, 0);
    check("cs_s1_data", alu_data, 1);
    @(negedge clk);
    check("cs_s2_op", alu_op, 1);
    @(negedge clk);
    check("cs_done", done, 1);
    check("cs_early", early, 0);
    check("cs_acc_final", acc_q, 1);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
